// File: rtl/chip_spreader.sv
// chip_spreader: splits each accepted byte into two 4-bit symbols and sends each as its
//   802.15.4 (2.4 GHz) 32-chip PN sequence, one chip per clock, c0 first.
// Latency: byte accepted at edge N -> chip 0 valid in the cycle after N; 64 valid cycles per byte.
// Backpressure: none from downstream; o_byte_ready is high in IDLE and in the last chip cycle only.
// Ports: i_clk, i_rst_n (async, active-low); i_byte/i_byte_valid/o_byte_ready input handshake;
//   o_stream/o_stream_valid chip output (feeds the I/Q generator); o_busy while a byte is in flight.
// Option: define CHIP_SPREADER_BYTE_CNT_EN to add o_byte_cnt[15:0], a wrapping count of bytes sent.
module chip_spreader #(
  parameter int CHIP_WIDTH       = 32,
  parameter bit LOW_NIBBLE_FIRST = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  output logic       o_stream,
  output logic       o_stream_valid,
  output logic       o_busy
`ifdef CHIP_SPREADER_BYTE_CNT_EN
  ,
  output logic [15:0] o_byte_cnt
`endif
);

  if (CHIP_WIDTH != 32) begin : g_bad_chip_width
    $error("chip_spreader: CHIP_WIDTH must be 32");
  end

  // Symbol 0 with c0 in bit 31.
  localparam logic [31:0] SYM0 = 32'b1101_1001_1100_0011_0101_0010_0010_1110;

  // Symbols 1..7 are symbol 0 rotated right by 4k chips; 8..15 additionally invert odd chips.
  function automatic logic chip_of(input logic [3:0] sym, input logic [4:0] idx);
    logic [4:0] base;
    base    = idx - {sym[2:0], 2'b00};  // wraps mod 32
    chip_of = SYM0[5'd31 - base] ^ (sym[3] & idx[0]);
  endfunction

  // sel=0 picks the nibble that goes first.
  function automatic logic [3:0] nib_of(input logic [7:0] b, input logic sel);
    nib_of = (sel ^ LOW_NIBBLE_FIRST) ? b[3:0] : b[7:4];
  endfunction

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t     r_state;
  logic [7:0] r_byte;
  logic [4:0] r_chip_cnt;
  logic       r_nib_sel;
  logic       r_stream;
  logic       r_stream_valid;
  logic       r_busy;
  logic       r_byte_ready;

  logic       w_last;
  logic       w_accept;
  logic [7:0] w_byte_nxt;
  logic [4:0] w_cnt_nxt;
  logic       w_nib_nxt;
  logic       w_chip_nxt;

  // Outputs are registered, so the chip for the next cycle is looked up one cycle early.
  always_comb begin
    w_last     = (r_state == SEND) && r_nib_sel && (r_chip_cnt == 5'd31);
    w_accept   = i_byte_valid && r_byte_ready;
    w_byte_nxt = w_accept ? i_byte : r_byte;
    w_cnt_nxt  = r_chip_cnt + 5'd1;
    w_nib_nxt  = (r_chip_cnt == 5'd31) ? ~r_nib_sel : r_nib_sel;
    if (w_accept) begin
      w_cnt_nxt = 5'd0;
      w_nib_nxt = 1'b0;
    end
    w_chip_nxt = chip_of(nib_of(w_byte_nxt, w_nib_nxt), w_cnt_nxt);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_byte         <= 8'h00;
      r_chip_cnt     <= 5'd0;
      r_nib_sel      <= 1'b0;
      r_stream       <= 1'b0;
      r_stream_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_byte_ready   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state        <= SEND;
            r_byte         <= i_byte;
            r_chip_cnt     <= 5'd0;
            r_nib_sel      <= 1'b0;
            r_stream       <= w_chip_nxt;
            r_stream_valid <= 1'b1;
            r_busy         <= 1'b1;
            r_byte_ready   <= 1'b0;
          end
        end
        SEND: begin
          if (w_accept) begin
            // Last chip of a byte with the next byte waiting: continue without a gap.
            r_byte         <= i_byte;
            r_chip_cnt     <= 5'd0;
            r_nib_sel      <= 1'b0;
            r_stream       <= w_chip_nxt;
            r_byte_ready   <= 1'b0;
          end else if (!w_last) begin
            r_chip_cnt     <= w_cnt_nxt;
            r_nib_sel      <= w_nib_nxt;
            r_stream       <= w_chip_nxt;
            r_byte_ready   <= w_nib_nxt && (w_cnt_nxt == 5'd31);
          end else begin
            r_state        <= IDLE;
            r_chip_cnt     <= 5'd0;
            r_nib_sel      <= 1'b0;
            r_stream       <= 1'b0;
            r_stream_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_byte_ready   <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_byte_ready   = r_byte_ready;
  assign o_stream       = r_stream;
  assign o_stream_valid = r_stream_valid;
  assign o_busy         = r_busy;

`ifdef CHIP_SPREADER_BYTE_CNT_EN
  logic [15:0] r_byte_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byte_cnt <= 16'h0000;
    end else if (w_last) begin
      r_byte_cnt <= r_byte_cnt + 16'h0001;
    end
  end

  assign o_byte_cnt = r_byte_cnt;
`endif

endmodule

// File: tb/tb_chip_spreader.sv
module tb_chip_spreader;

  localparam int MAXC = 1024;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_byte;
  logic       i_byte_valid;
  logic       rdy_lo, st_lo, sv_lo, busy_lo;
  logic       rdy_hi, st_hi, sv_hi, busy_hi;
`ifdef CHIP_SPREADER_BYTE_CNT_EN
  logic [15:0] cnt_lo, cnt_hi;
`endif

  always #5 clk = ~clk;

  chip_spreader #(.CHIP_WIDTH(32), .LOW_NIBBLE_FIRST(1'b1)) dut_lo (
    .i_clk(clk), .i_rst_n(rst_n), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_byte_ready(rdy_lo), .o_stream(st_lo), .o_stream_valid(sv_lo), .o_busy(busy_lo)
`ifdef CHIP_SPREADER_BYTE_CNT_EN
    , .o_byte_cnt(cnt_lo)
`endif
  );

  chip_spreader #(.CHIP_WIDTH(32), .LOW_NIBBLE_FIRST(1'b0)) dut_hi (
    .i_clk(clk), .i_rst_n(rst_n), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_byte_ready(rdy_hi), .o_stream(st_hi), .o_stream_valid(sv_hi), .o_busy(busy_hi)
`ifdef CHIP_SPREADER_BYTE_CNT_EN
    , .o_byte_cnt(cnt_hi)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference chip table, tbl[symbol][chip index], built from the symbol-0 string.
  logic tbl [16][32];

  // Captured cycles (sampled at negedge) and the model's expectations for them.
  logic [7:0] tx_q [$];
  int         ncap;
  int         n_acc;
  logic       cv_lo [MAXC], cs_lo [MAXC], cr_lo [MAXC], cb_lo [MAXC];
  logic       cv_hi [MAXC], cs_hi [MAXC], cr_hi [MAXC], cb_hi [MAXC];
  bit         acc   [MAXC];
  logic [7:0] acc_b [MAXC];
  logic       ev [MAXC], er [MAXC], es_lo [MAXC], es_hi [MAXC];

  function automatic logic exp_chip(input logic [7:0] b, input int p, input bit lnf);
    bit         first_half;
    logic [3:0] nib;
    first_half = (p < 32);
    nib = (first_half == lnf) ? b[3:0] : b[7:4];
    return tbl[nib][p % 32];
  endfunction

  // Behavioural model: every accepted byte becomes 64 chips queued behind the bytes already
  // accepted; the output is valid whenever chips are pending, ready when at most one remains.
  function automatic void build_expect();
    logic [7:0] pend [$];
    int         pos;
    int         remain;
    pos = 0;
    for (int c = 0; c < ncap; c++) begin
      remain   = (pend.size() == 0) ? 0 : 64 * pend.size() - pos;
      ev[c]    = (remain > 0);
      er[c]    = (remain <= 1);
      es_lo[c] = 1'b0;
      es_hi[c] = 1'b0;
      if (remain > 0) begin
        es_lo[c] = exp_chip(pend[0], pos, 1'b1);
        es_hi[c] = exp_chip(pend[0], pos, 1'b0);
        pos++;
        if (pos == 64) begin
          pos = 0;
          void'(pend.pop_front());
        end
      end
      if (acc[c]) pend.push_back(acc_b[c]);
    end
  endfunction

  // Offers tx_q bytes (optionally with random valid gaps and garbage on i_byte while it
  // cannot be taken) and records ncyc cycles of both instances' outputs.
  task automatic drive_capture(input int ncyc, input bit gaps, input bit scramble);
    int idx;
    idx  = 0;
    ncap = ncyc;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (idx < tx_q.size()) begin
        i_byte       = tx_q[idx];
        i_byte_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else begin
        i_byte_valid = 1'b0;
      end
      cv_lo[c] = sv_lo; cs_lo[c] = st_lo; cr_lo[c] = rdy_lo; cb_lo[c] = busy_lo;
      cv_hi[c] = sv_hi; cs_hi[c] = st_hi; cr_hi[c] = rdy_hi; cb_hi[c] = busy_hi;
      acc[c]   = i_byte_valid && rdy_lo;
      acc_b[c] = i_byte;
      @(posedge clk);
      #1;
      if (acc[c]) idx++;
      if (scramble) i_byte = 8'($urandom);
    end
    n_acc = idx;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_byte = 8'h00; i_byte_valid = 1'b0;
    #12;
    n_cmp++;
    if ({sv_lo, busy_lo, rdy_lo, st_lo} !== 4'b0010) begin
      n_bad++; $display("FAIL reset_lo: vld/busy/rdy/chip = %b%b%b%b, want 0010", sv_lo, busy_lo, rdy_lo, st_lo);
    end
    n_cmp++;
    if ({sv_hi, busy_hi, rdy_hi, st_hi} !== 4'b0010) begin
      n_bad++; $display("FAIL reset_hi: vld/busy/rdy/chip = %b%b%b%b, want 0010", sv_hi, busy_hi, rdy_hi, st_hi);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({sv_lo, busy_lo, rdy_lo, sv_hi, busy_hi, rdy_hi} !== 6'b001001) begin
      n_bad++; $display("FAIL idle_after_reset: lo vld/busy/rdy = %b%b%b hi = %b%b%b, want 001/001",
                        sv_lo, busy_lo, rdy_lo, sv_hi, busy_hi, rdy_hi);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_byte();
    int  nv, nrl;
    logic [7:0] head;
    tx_q = '{8'h00};
    drive_capture(70, 1'b0, 1'b0);
    build_expect();
    nv = 0; nrl = 0; head = 8'h00;
    for (int c = 0; c < ncap; c++) begin
      n_cmp++;
      if (cv_lo[c] !== ev[c] || cb_lo[c] !== ev[c] || cr_lo[c] !== er[c] || (ev[c] && cs_lo[c] !== es_lo[c]) ||
          cv_hi[c] !== ev[c] || cb_hi[c] !== ev[c] || cr_hi[c] !== er[c] || (ev[c] && cs_hi[c] !== es_hi[c])) begin
        n_bad++;
        $display("FAIL single cyc %0d: lo vld/busy/rdy/chip=%b%b%b%b hi=%b%b%b%b, want vld/rdy=%b%b chip lo/hi=%b/%b",
                 c, cv_lo[c], cb_lo[c], cr_lo[c], cs_lo[c], cv_hi[c], cb_hi[c], cr_hi[c], cs_hi[c],
                 ev[c], er[c], es_lo[c], es_hi[c]);
      end
      if (cv_lo[c] === 1'b1) begin
        if (nv < 8) head = {head[6:0], cs_lo[c]};
        nv++;
        if (cr_lo[c] === 1'b0) nrl++;
      end
    end
    n_cmp++;
    if (nv != 64) begin n_bad++; $display("FAIL single_len: %0d valid cycles, want 64", nv); end
    n_cmp++;
    if (nrl != 63) begin n_bad++; $display("FAIL single_ready_low: %0d cycles, want 63", nrl); end
    n_cmp++;
    if (head !== 8'b11011001) begin n_bad++; $display("FAIL single_head: %b, want 11011001", head); end
  endtask

  task automatic test_symbol_map();
    int f;
    logic [31:0] la, lb, ha, hb;
    tx_q = '{8'h18};
    drive_capture(70, 1'b0, 1'b0);
    f = -1;
    for (int c = 0; c < ncap; c++) if (f < 0 && cv_lo[c] === 1'b1) f = c;
    la = '0; lb = '0; ha = '0; hb = '0;
    if (f >= 0 && f + 64 <= ncap) begin
      for (int j = 0; j < 32; j++) begin
        la = {la[30:0], cs_lo[f + j]};  lb = {lb[30:0], cs_lo[f + 32 + j]};
        ha = {ha[30:0], cs_hi[f + j]};  hb = {hb[30:0], cs_hi[f + 32 + j]};
      end
    end
    n_cmp++;
    if (la !== 32'b1000_1100_1001_0110_0000_0111_0111_1011) begin
      n_bad++; $display("FAIL map18_lnf1_first: %b, want sym 8", la);
    end
    n_cmp++;
    if (lb !== 32'b1110_1101_1001_1100_0011_0101_0010_0010) begin
      n_bad++; $display("FAIL map18_lnf1_second: %b, want sym 1", lb);
    end
    n_cmp++;
    if (ha !== 32'b1110_1101_1001_1100_0011_0101_0010_0010) begin
      n_bad++; $display("FAIL map18_lnf0_first: %b, want sym 1", ha);
    end
    n_cmp++;
    if (hb !== 32'b1000_1100_1001_0110_0000_0111_0111_1011) begin
      n_bad++; $display("FAIL map18_lnf0_second: %b, want sym 8", hb);
    end
  endtask

  task automatic test_back_to_back();
    int f, run;
    tx_q = '{8'hA5, 8'h3C, 8'hFF};
    drive_capture(200, 1'b0, 1'b0);
    build_expect();
    for (int c = 0; c < ncap; c++) begin
      n_cmp++;
      if (cv_lo[c] !== ev[c] || cb_lo[c] !== ev[c] || cr_lo[c] !== er[c] || (ev[c] && cs_lo[c] !== es_lo[c]) ||
          cv_hi[c] !== ev[c] || cb_hi[c] !== ev[c] || cr_hi[c] !== er[c] || (ev[c] && cs_hi[c] !== es_hi[c])) begin
        n_bad++;
        $display("FAIL b2b cyc %0d: lo vld/busy/rdy/chip=%b%b%b%b hi=%b%b%b%b, want vld/rdy=%b%b chip lo/hi=%b/%b",
                 c, cv_lo[c], cb_lo[c], cr_lo[c], cs_lo[c], cv_hi[c], cb_hi[c], cr_hi[c], cs_hi[c],
                 ev[c], er[c], es_lo[c], es_hi[c]);
      end
    end
    f = -1;
    for (int c = 0; c < ncap; c++) if (f < 0 && cv_lo[c] === 1'b1) f = c;
    run = 0;
    if (f >= 0) while (f + run < ncap && cv_lo[f + run] === 1'b1) run++;
    n_cmp++;
    if (run != 192) begin n_bad++; $display("FAIL b2b_contiguous: run of %0d valid cycles, want 192", run); end
  endtask

  task automatic test_random();
    tx_q.delete();
    repeat (6) tx_q.push_back(8'($urandom));
    drive_capture(6 * 64 + 120, 1'b1, 1'b1);
    build_expect();
    for (int c = 0; c < ncap; c++) begin
      n_cmp++;
      if (cv_lo[c] !== ev[c] || cb_lo[c] !== ev[c] || cr_lo[c] !== er[c] || (ev[c] && cs_lo[c] !== es_lo[c]) ||
          cv_hi[c] !== ev[c] || cb_hi[c] !== ev[c] || cr_hi[c] !== er[c] || (ev[c] && cs_hi[c] !== es_hi[c])) begin
        n_bad++;
        $display("FAIL random cyc %0d: lo vld/busy/rdy/chip=%b%b%b%b hi=%b%b%b%b, want vld/rdy=%b%b chip lo/hi=%b/%b",
                 c, cv_lo[c], cb_lo[c], cr_lo[c], cs_lo[c], cv_hi[c], cb_hi[c], cr_hi[c], cs_hi[c],
                 ev[c], er[c], es_lo[c], es_hi[c]);
      end
    end
    n_cmp++;
    if (n_acc != 6) begin n_bad++; $display("FAIL random_accepted: %0d bytes, want 6", n_acc); end
    n_cmp++;
    if (ev[ncap - 1] !== 1'b0 || cv_lo[ncap - 1] !== 1'b0) begin
      n_bad++; $display("FAIL random_drain: final vld=%b, want 0", cv_lo[ncap - 1]);
    end
  endtask

  task automatic test_reset_mid();
    i_byte = 8'h96; i_byte_valid = 1'b1;
    @(posedge clk); #1;
    i_byte_valid = 1'b0;
    repeat (52) @(posedge clk);  // now in the cycle carrying chip 20 of the second symbol
    #2;
    n_cmp++;
    if (sv_lo !== 1'b1 || busy_lo !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_pre: vld/busy=%b%b, want 11", sv_lo, busy_lo);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sv_lo, busy_lo, rdy_lo, sv_hi, busy_hi, rdy_hi} !== 6'b001001) begin
      n_bad++; $display("FAIL rstmid_immediate: lo vld/busy/rdy=%b%b%b hi=%b%b%b, want 001/001",
                        sv_lo, busy_lo, rdy_lo, sv_hi, busy_hi, rdy_hi);
    end
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (sv_lo !== 1'b0 || busy_lo !== 1'b0 || rdy_lo !== 1'b1 || sv_hi !== 1'b0) begin
        n_bad++; $display("FAIL rstmid_after %0d: vld/busy/rdy=%b%b%b, want 001", k, sv_lo, busy_lo, rdy_lo);
      end
    end
    @(posedge clk); #1;
    tx_q = '{8'h00};
    drive_capture(70, 1'b0, 1'b0);
    build_expect();
    for (int c = 0; c < ncap; c++) begin
      n_cmp++;
      if (cv_lo[c] !== ev[c] || cb_lo[c] !== ev[c] || cr_lo[c] !== er[c] || (ev[c] && cs_lo[c] !== es_lo[c]) ||
          cv_hi[c] !== ev[c] || cb_hi[c] !== ev[c] || cr_hi[c] !== er[c] || (ev[c] && cs_hi[c] !== es_hi[c])) begin
        n_bad++;
        $display("FAIL rstmid_burst cyc %0d: lo vld/busy/rdy/chip=%b%b%b%b, want vld/rdy=%b%b chip=%b",
                 c, cv_lo[c], cb_lo[c], cr_lo[c], cs_lo[c], ev[c], er[c], es_lo[c]);
      end
    end
  endtask

`ifdef CHIP_SPREADER_BYTE_CNT_EN
  task automatic test_byte_cnt();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if (cnt_lo !== 16'h0000) begin n_bad++; $display("FAIL bytecnt_reset: %h, want 0000", cnt_lo); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    tx_q = '{8'h11, 8'h22, 8'h33};
    drive_capture(200, 1'b0, 1'b0);
    n_cmp++;
    if (cnt_lo !== 16'd3 || cnt_hi !== 16'd3) begin
      n_bad++; $display("FAIL bytecnt_three: lo=%0d hi=%0d, want 3", cnt_lo, cnt_hi);
    end
    force dut_lo.r_byte_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut_lo.r_byte_cnt;
    tx_q = '{8'h44};
    drive_capture(70, 1'b0, 1'b0);
    n_cmp++;
    if (cnt_lo !== 16'h0000) begin n_bad++; $display("FAIL bytecnt_wrap: %h, want 0000", cnt_lo); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:31] s0;
    s0 = 32'b11011001110000110101001000101110;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 32; j++) begin
        tbl[k][j]     = s0[(j + 32 - 4 * k) % 32];
        tbl[k + 8][j] = s0[(j + 32 - 4 * k) % 32] ^ (j % 2 == 1);
      end
    end
    test_reset();
    test_single_byte();
    test_symbol_map();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef CHIP_SPREADER_BYTE_CNT_EN
    test_byte_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chip_spreader.md
Name: chip_spreader

Overview:
- Upstream neighbour of the I/Q stream generator in the transmitter.
- Accepts PSDU bytes through a valid/ready handshake and splits each byte into two 4-bit symbols.
- Maps each symbol to its IEEE 802.15.4 2.4 GHz 32-chip PN sequence.
- Serialises the chips one per clock as o_stream/o_stream_valid, which connect directly to the I/Q generator's i_stream/i_stream_valid.

Parameters:
- CHIP_WIDTH, 32, chips per symbol; only 32 is supported; any other value is a compile-time error.
- LOW_NIBBLE_FIRST, 1, 1: send bits [3:0] then [7:4]; 0: send bits [7:4] then [3:0].

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_byte  input  8  data byte.
- i_byte_valid  input  1  i_byte holds valid data.
- o_byte_ready  output  1  block accepts i_byte this cycle.
- o_stream  output  1  current chip.
- o_stream_valid  output  1  o_stream is valid.
- o_busy  output  1  a byte is being serialised.

Behaviour:
- One clock (i_clk). Reset is asynchronous and active-low (i_rst_n); all flops clear immediately on assertion.
- Reset values: state IDLE, chip_cnt 0, nib_sel 0, o_stream 0, o_stream_valid 0, o_busy 0, o_byte_ready 1.
- Chip table, c0 transmitted first:
  - Symbol 0 = 1101 1001 1100 0011 0101 0010 0010 1110.
  - Symbols k = 1..7 = symbol 0 cyclically shifted right by 4k chips (c(j) of sym k = c((j-4k) mod 32) of sym 0).
  - Symbols 8..15 = symbols 0..7 with every odd-indexed chip (c1, c3, ...) inverted.
  - Implemented as a constant ROM or shift logic; result must be identical.
- FSM, two states:
  - IDLE: o_byte_ready=1, o_stream_valid=0, o_busy=0. On i_byte_valid && o_byte_ready: latch byte, chip_cnt<=0, nib_sel<=0, go to SEND.
  - SEND: o_stream_valid=1, o_busy=1, o_stream = chip[chip_cnt] of the current symbol. chip_cnt increments every cycle, wrapping 31->0. On the wrap, nib_sel toggles.
  - o_byte_ready=0 in SEND except in the final cycle (nib_sel=1 and chip_cnt=31).
  - Final cycle with i_byte_valid=1: new byte accepted; next cycle is chip 0 of its first symbol with no gap; state stays SEND.
  - Final cycle with i_byte_valid=0: next state is IDLE.
- Latency: byte accepted at edge N; first chip valid in the cycle after edge N. Each byte occupies exactly 64 consecutive valid cycles.
- Back-to-back streaming: o_stream_valid stays continuously high across bytes. This is required so the I/Q generator's I/Q alternation never slips within a frame.
- i_byte is sampled only on acceptance. Changes to i_byte during SEND have no effect.
- Reset mid-byte: the byte is discarded and o_stream_valid drops immediately. After release, the block is in IDLE with ready=1.
- No backpressure from downstream; the consumer must take one chip per cycle.

Optional Feature:
- Macro: CHIP_SPREADER_BYTE_CNT_EN.
- Defined:
  - Adds output port o_byte_cnt [15:0], reset 0.
  - Increments in the final chip cycle of every byte; wraps 0xFFFF->0x0000.
  - Lets the framing logic detect end of PSDU.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then i_byte=0x00 with valid for one cycle -> 64 valid cycles carrying symbol 0 twice, starting 11011001... Ready is low for 63 of them and high on the 64th. Then IDLE: valid=0, ready=1.
- i_byte=0x18, LOW_NIBBLE_FIRST=1 -> first 32 chips 1000 1100 1001 0110 0000 0111 0111 1011 (sym 8). Next 32 chips 1110 1101 1001 1100 0011 0101 0010 0010 (sym 1).
- Bytes 0xA5, 0x3C, 0xFF held valid continuously -> 192 contiguous valid cycles with zero gap cycles. Symbol order 5, A, C, 3, F, F; each symbol checked against a table model.
- LOW_NIBBLE_FIRST=0, i_byte=0x18 -> sym 1 chips then sym 8 chips.
- i_rst_n asserted at chip 20 of the second symbol -> o_stream_valid=0 and o_busy=0 in the same cycle, with no partial chips after release. Next byte 0x00 produces a clean 64-chip burst.
- With CHIP_SPREADER_BYTE_CNT_EN defined: 3 bytes -> o_byte_cnt=3. Preloading via 65536 bytes (or force) -> o_byte_cnt wraps to 0.
